// File: rtl/des_crypt_unroll_if.sv
// des_crypt_unroll_if
//   Request/response bundle for the des_crypt_unroll core.
//   start, decrypt, message[1:64], round_keys[1:768] : requester -> core
//   busy, done, result[1:64]                         : core -> requester
//   master : requester side (key-search top level or bench)
//   slave  : core side
interface des_crypt_unroll_if;
    logic         start;
    logic         decrypt;
    logic [1:64]  message;
    logic [1:768] round_keys;
    logic         busy;
    logic         done;
    logic [1:64]  result;

    modport master (output start, decrypt, message, round_keys,
                    input  busy, done, result);
    modport slave  (input  start, decrypt, message, round_keys,
                    output busy, done, result);
endinterface

// File: rtl/des_crypt_unroll.sv
// des_crypt_unroll
//   Iterative DES core evaluating UNROLL Feistel rounds per clock
//   (UNROLL = 1, 2, 4, 8 or 16; 16/UNROLL round cycles per block).
//   Encrypt/decrypt chosen per block by reversing the round-key order.
//   Ports:
//     clk   : rising-edge clock
//     rst_n : asynchronous active-low reset
//     bus   : des_crypt_unroll_if.slave (start/decrypt/message/round_keys in,
//             busy/done/result out; DES bit numbering, bit 1 = MSB)
//   Build option:
//     DES_KEYS_LIVE_EN : round keys read from the port every round cycle
//                        instead of being latched at start; the driver must
//                        hold round_keys stable from start until done.
module des_crypt_unroll #(
    parameter int UNROLL = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    des_crypt_unroll_if.slave bus
);
    localparam int unsigned ROUND_CYCLES = 16 / UNROLL;
    localparam int unsigned UR           = UNROLL;
    localparam int unsigned CNT_W        = (ROUND_CYCLES > 1) ? $clog2(ROUND_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ROUND_CYCLES - 1);

    if (!(UNROLL == 1 || UNROLL == 2 || UNROLL == 4 || UNROLL == 8 || UNROLL == 16)) begin : g_bad_unroll
        $fatal(1, "des_crypt_unroll: UNROLL must be 1, 2, 4, 8 or 16");
    end

    localparam logic [6:0] IP_T [1:64] = '{
        58, 50, 42, 34, 26, 18, 10, 2, 60, 52, 44, 36, 28, 20, 12, 4,
        62, 54, 46, 38, 30, 22, 14, 6, 64, 56, 48, 40, 32, 24, 16, 8,
        57, 49, 41, 33, 25, 17,  9, 1, 59, 51, 43, 35, 27, 19, 11, 3,
        61, 53, 45, 37, 29, 21, 13, 5, 63, 55, 47, 39, 31, 23, 15, 7};
    localparam logic [6:0] FP_T [1:64] = '{
        40, 8, 48, 16, 56, 24, 64, 32, 39, 7, 47, 15, 55, 23, 63, 31,
        38, 6, 46, 14, 54, 22, 62, 30, 37, 5, 45, 13, 53, 21, 61, 29,
        36, 4, 44, 12, 52, 20, 60, 28, 35, 3, 43, 11, 51, 19, 59, 27,
        34, 2, 42, 10, 50, 18, 58, 26, 33, 1, 41,  9, 49, 17, 57, 25};
    localparam logic [5:0] E_T [1:48] = '{
        32,  1,  2,  3,  4,  5,  4,  5,  6,  7,  8,  9,  8,  9, 10, 11,
        12, 13, 12, 13, 14, 15, 16, 17, 16, 17, 18, 19, 20, 21, 20, 21,
        22, 23, 24, 25, 24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32,  1};
    localparam logic [5:0] P_T [1:32] = '{
        16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
         2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25};
    // Each S-box is 64 nibbles, row-major, first nibble at bit 0.
    localparam logic [0:255] SBOX [1:8] = '{
        256'hE4D12FB83A6C59070F74E2D1A6CB953841E8D62BFC973A50FC8249175B3EA06D,
        256'hF18E6B34972DC05A3D47F28EC01A69B50E7BA4D158C6932FD8A13F42B67C05E9,
        256'hA09E63F51DC7B428D70934A6285ECBF1D6498F30B12C5AE71AD069874FE3B52C,
        256'h7DE3069A1285BC4FD8B56F03472C1AE9A690CB7DF13E52843F06A1D8945BC72E,
        256'h2C417AB6853FD0E9EB2C47D150FA3986421BAD78F9C5630EB8C71E2D6F09A453,
        256'hC1AF92680D34E75BAF427C9561DE0B389EF528C3704A1DB6432C95FABE17608D,
        256'h4B2EF08D3C975A61D0B7491AE35C2F8614BDC37EAF6805926BD814A7950FE23C,
        256'hD2846FB1A93E50C71FD8A374C56B0E927B419CE206ADF35821E74A8DFC90356B};

    function automatic logic [1:64] perm_ip(input logic [1:64] x);
        logic [1:64] o;
        for (int unsigned i = 1; i <= 64; i++) o[i] = x[IP_T[i]];
        return o;
    endfunction

    function automatic logic [1:64] perm_fp(input logic [1:64] x);
        logic [1:64] o;
        for (int unsigned i = 1; i <= 64; i++) o[i] = x[FP_T[i]];
        return o;
    endfunction

    function automatic logic [1:32] feistel(input logic [1:32] r, input logic [1:48] k);
        logic [1:48] x;
        logic [1:6]  six;
        logic [5:0]  sel;
        logic [1:32] s;
        logic [1:32] o;
        for (int unsigned i = 1; i <= 48; i++) x[i] = r[E_T[i]] ^ k[i];
        for (int unsigned b = 0; b < 8; b++) begin
            six = x[6*b+1 +: 6];
            // outer bits pick the row, inner four bits the column
            sel = {six[1], six[6], six[2:5]};
            s[4*b+1 +: 4] = SBOX[b+1][{sel, 2'b00} +: 4];
        end
        for (int unsigned i = 1; i <= 32; i++) o[i] = s[P_T[i]];
        return o;
    endfunction

    typedef enum logic {S_IDLE, S_ROUND} state_t;

    state_t           state_q, state_d;
    logic [1:32]      l_q, l_d, r_q, r_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             dec_q, dec_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [1:64]      result_q, result_d;
    logic [1:768]     keys_src;
    logic             accept;

    assign accept = (state_q == S_IDLE) && bus.start;

`ifdef DES_KEYS_LIVE_EN
    assign keys_src = bus.round_keys;
`else
    logic [1:768] keys_q, keys_d;

    assign keys_d   = accept ? bus.round_keys : keys_q;
    assign keys_src = keys_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) keys_q <= '0;
        else        keys_q <= keys_d;
    end
`endif

    // UNROLL rounds chained combinationally; global round index is cnt*UNROLL+u+1.
    logic [1:32]  l_n, r_n, tmp;
    logic [1:48]  rkey;
    int unsigned  rnd, kidx;
    logic [9:0]   kbase;

    always_comb begin
        l_n   = l_q;
        r_n   = r_q;
        tmp   = '0;
        rkey  = '0;
        rnd   = 0;
        kidx  = 0;
        kbase = '0;
        for (int unsigned u = 0; u < UR; u++) begin
            rnd   = 32'(cnt_q) * UR + u + 1;
            kidx  = dec_q ? (17 - rnd) : rnd;
            kbase = 10'(48 * (kidx - 1) + 1);
            rkey  = keys_src[kbase +: 48];
            tmp   = r_n;
            r_n   = l_n ^ feistel(r_n, rkey);
            l_n   = tmp;
        end
    end

    always_comb begin
        state_d  = state_q;
        l_d      = l_q;
        r_d      = r_q;
        cnt_d    = cnt_q;
        dec_d    = dec_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        result_d = result_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    {l_d, r_d} = perm_ip(bus.message);
                    dec_d      = bus.decrypt;
                    cnt_d      = '0;
                    busy_d     = 1'b1;
                    state_d    = S_ROUND;
                end
            end
            S_ROUND: begin
                l_d   = l_n;
                r_d   = r_n;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    // no swap after round 16: R16||L16 feeds FP directly
                    result_d = perm_fp({r_n, l_n});
                    done_d   = 1'b1;
                    busy_d   = 1'b0;
                    cnt_d    = '0;
                    state_d  = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            l_q      <= '0;
            r_q      <= '0;
            cnt_q    <= '0;
            dec_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            l_q      <= l_d;
            r_q      <= r_d;
            cnt_q    <= cnt_d;
            dec_q    <= dec_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            result_q <= result_d;
        end
    end

    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.result = result_q;
endmodule

// File: tb/tb_des_crypt_unroll.sv
// tb_des_crypt_unroll
//   Drives five des_crypt_unroll instances (UNROLL = 1, 2, 4, 8, 16) from one
//   shared stimulus set with per-instance start lines, and compares them with
//   a bit-list DES reference (key schedule, IP, rounds, inverse-IP) plus known
//   answer vectors.
module tb_des_crypt_unroll;
    logic         clk        = 1'b0;
    logic         rst_n      = 1'b0;
    logic [4:0]   start_v    = '0;
    logic         dec        = 1'b0;
    logic [1:64]  message    = '0;
    logic [1:768] round_keys = '0;
    logic [4:0]   busy_v;
    logic [4:0]   done_v;
    logic [1:64]  result_v [5];
    int           checks     = 0;
    int           failures   = 0;

    int           dk [$];
    logic [63:0]  dr [$];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 5; g++) begin : g_dut
        des_crypt_unroll_if bus ();
        assign bus.start      = start_v[g];
        assign bus.decrypt    = dec;
        assign bus.message    = message;
        assign bus.round_keys = round_keys;
        assign busy_v[g]      = bus.busy;
        assign done_v[g]      = bus.done;
        assign result_v[g]    = bus.result;
        des_crypt_unroll #(.UNROLL(1 << g)) dut (
            .clk   (clk),
            .rst_n (rst_n),
            .bus   (bus)
        );
    end

    int ip_t [64] = '{58,50,42,34,26,18,10,2,60,52,44,36,28,20,12,4,62,54,46,38,30,22,14,6,64,56,48,40,32,24,16,8,
                      57,49,41,33,25,17,9,1,59,51,43,35,27,19,11,3,61,53,45,37,29,21,13,5,63,55,47,39,31,23,15,7};
    int e_t [48]  = '{32,1,2,3,4,5,4,5,6,7,8,9,8,9,10,11,12,13,12,13,14,15,16,17,
                      16,17,18,19,20,21,20,21,22,23,24,25,24,25,26,27,28,29,28,29,30,31,32,1};
    int p_t [32]  = '{16,7,20,21,29,12,28,17,1,15,23,26,5,18,31,10,2,8,24,14,32,27,3,9,19,13,30,6,22,11,4,25};
    int pc1_t [56] = '{57,49,41,33,25,17,9,1,58,50,42,34,26,18,10,2,59,51,43,35,27,19,11,3,60,52,44,36,
                       63,55,47,39,31,23,15,7,62,54,46,38,30,22,14,6,61,53,45,37,29,21,13,5,28,20,12,4};
    int pc2_t [48] = '{14,17,11,24,1,5,3,28,15,6,21,10,23,19,12,4,26,8,16,7,27,20,13,2,
                       41,52,31,37,47,55,30,40,51,45,33,48,44,49,39,56,34,53,46,42,50,36,29,32};
    int sh_t [16]  = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};
    logic [255:0] sb_t [8] = '{
        256'hE4D12FB83A6C59070F74E2D1A6CB953841E8D62BFC973A50FC8249175B3EA06D,
        256'hF18E6B34972DC05A3D47F28EC01A69B50E7BA4D158C6932FD8A13F42B67C05E9,
        256'hA09E63F51DC7B428D70934A6285ECBF1D6498F30B12C5AE71AD069874FE3B52C,
        256'h7DE3069A1285BC4FD8B56F03472C1AE9A690CB7DF13E52843F06A1D8945BC72E,
        256'h2C417AB6853FD0E9EB2C47D150FA3986421BAD78F9C5630EB8C71E2D6F09A453,
        256'hC1AF92680D34E75BAF427C9561DE0B389EF528C3704A1DB6432C95FABE17608D,
        256'h4B2EF08D3C975A61D0B7491AE35C2F8614BDC37EAF6805926BD814A7950FE23C,
        256'hD2846FB1A93E50C71FD8A374C56B0E927B419CE206ADF35821E74A8DFC90356B};

    // bit 'pos' (1 = MSB) of a w-bit value held right-aligned in x
    function automatic logic tbit(input logic [63:0] x, input int w, input int pos);
        return ((x >> (w - pos)) & 64'd1) != 64'd0;
    endfunction

    function automatic logic [767:0] key_sched(input logic [63:0] k);
        logic [55:0]  cd;
        logic [27:0]  c, d;
        logic [47:0]  sk;
        logic [767:0] ks;
        cd = '0;
        ks = '0;
        for (int i = 0; i < 56; i++) cd = {cd[54:0], tbit(k, 64, pc1_t[i])};
        c = cd[55:28];
        d = cd[27:0];
        for (int r = 0; r < 16; r++) begin
            for (int s = 0; s < sh_t[r]; s++) begin
                c = {c[26:0], c[27]};
                d = {d[26:0], d[27]};
            end
            cd = {c, d};
            sk = '0;
            for (int i = 0; i < 48; i++) sk = {sk[46:0], tbit({8'h0, cd}, 56, pc2_t[i])};
            ks = {ks[719:0], sk};
        end
        return ks;
    endfunction

    function automatic logic [31:0] f_model(input logic [31:0] r, input logic [47:0] k);
        logic [47:0] x;
        logic [31:0] s, o;
        int six, idx;
        x = '0;
        for (int i = 0; i < 48; i++) x = {x[46:0], tbit({32'h0, r}, 32, e_t[i])};
        x = x ^ k;
        s = '0;
        for (int b = 0; b < 8; b++) begin
            six = int'((x >> (42 - 6 * b)) & 48'h3F);
            idx = ((six >> 5) & 1) * 32 + (six & 1) * 16 + ((six >> 1) & 15);
            s = {s[27:0], 4'((sb_t[b] >> (4 * (63 - idx))) & 256'hF)};
        end
        o = '0;
        for (int i = 0; i < 32; i++) o = {o[30:0], tbit({32'h0, s}, 32, p_t[i])};
        return o;
    endfunction

    function automatic logic [63:0] des_model(input logic [63:0] m, input logic [767:0] ks, input logic d);
        logic [63:0] t, pre, res;
        logic [31:0] l, r, tmp;
        int kidx;
        t = '0;
        for (int i = 0; i < 64; i++) t = {t[62:0], tbit(m, 64, ip_t[i])};
        l = t[63:32];
        r = t[31:0];
        for (int rnd = 1; rnd <= 16; rnd++) begin
            kidx = d ? 17 - rnd : rnd;
            tmp  = r;
            r    = l ^ f_model(r, 48'(ks >> (48 * (16 - kidx))));
            l    = tmp;
        end
        pre = {r, l};
        res = '0;
        // final permutation = inverse of IP
        for (int i = 0; i < 64; i++)
            if (tbit(pre, 64, i + 1)) res = res | (64'd1 << (64 - ip_t[i]));
        return res;
    endfunction

    function automatic logic [767:0] rand768();
        logic [767:0] v;
        v = '0;
        for (int i = 0; i < 24; i++) v = {v[735:0], 32'($urandom)};
        return v;
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        checks++;
        assert (got === want) else begin
            failures++;
            $error("FAIL %s got=%h want=%h", tag, got, want);
        end
    endtask

    // One block on the instances in mask; optionally scramble inputs while busy.
    task automatic run_op(input logic [4:0] mask, input logic [63:0] msg, input logic [767:0] keys,
                          input logic d, input logic [63:0] exp_res, input string tag, input bit scramble);
        int          dcnt [5];
        int          dcyc [5];
        int          bbad [5];
        logic [63:0] dres [5];
        for (int g = 0; g < 5; g++) begin
            dcnt[g] = 0; dcyc[g] = -1; bbad[g] = 0; dres[g] = '0;
        end
        @(negedge clk);
        message = msg; round_keys = keys; dec = d; start_v = mask;
        @(negedge clk);
        start_v = '0;
        for (int k = 0; k < 20; k++) begin
            for (int g = 0; g < 5; g++) begin
                if (mask[g]) begin
                    if (done_v[g]) begin
                        dcnt[g]++;
                        if (dcnt[g] == 1) begin dcyc[g] = k; dres[g] = result_v[g]; end
                    end
                    if (busy_v[g] !== ((k < (16 >> g)) ? 1'b1 : 1'b0)) bbad[g]++;
                end
            end
            if (scramble) begin
                message    = {$urandom, $urandom};
                round_keys = rand768();
                dec        = 1'($urandom);
            end
            @(negedge clk);
        end
        for (int g = 0; g < 5; g++) begin
            if (mask[g]) begin
                chk($sformatf("%s U=%0d done_count", tag, 1 << g), 64'(dcnt[g]), 64'd1);
                chk($sformatf("%s U=%0d latency", tag, 1 << g), 64'(dcyc[g]), 64'(16 >> g));
                chk($sformatf("%s U=%0d result", tag, 1 << g), dres[g], exp_res);
                chk($sformatf("%s U=%0d busy_errs", tag, 1 << g), 64'(bbad[g]), 64'd0);
                chk($sformatf("%s U=%0d result_hold", tag, 1 << g), result_v[g], exp_res);
            end
        end
    endtask

    // Drive one block into the UNROLL=4 instance, a second start at cycle s2, log every done.
    task automatic trace_u4(input logic [63:0] m1, input logic [767:0] k1, input int s2,
                            input logic [63:0] m2, input logic [767:0] k2, input int ncyc);
        dk.delete();
        dr.delete();
        @(negedge clk);
        message = m1; round_keys = k1; dec = 1'b0; start_v = 5'b00100;
        @(negedge clk);
        start_v = '0;
        for (int k = 0; k < ncyc; k++) begin
            if (done_v[2]) begin dk.push_back(k); dr.push_back(result_v[2]); end
            if (k == s2) begin
                message = m2; round_keys = k2; start_v = 5'b00100;
            end else begin
                start_v = '0;
            end
            @(negedge clk);
        end
        start_v = '0;
    endtask

    initial begin
        logic [767:0] ks_a, ks_w, ks_r, ks_b;
        logic [63:0]  m, c, ma, mb, mc;
        int           late_done;

        // reset state
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        for (int g = 0; g < 5; g++) begin
            chk($sformatf("reset U=%0d busy", 1 << g), 64'(busy_v[g]), 64'd0);
            chk($sformatf("reset U=%0d done", 1 << g), 64'(done_v[g]), 64'd0);
            chk($sformatf("reset U=%0d result", 1 << g), result_v[g], 64'd0);
        end

        // known-answer vectors
        ks_a = key_sched(64'h133457799BBCDFF1);
        ks_w = key_sched(64'h0101010101010101);
        run_op(5'h1F, 64'h0123456789ABCDEF, ks_a, 1'b0, 64'h85E813540F0AB405, "kat_enc", 1'b1);
        run_op(5'h1F, 64'h85E813540F0AB405, ks_a, 1'b1, 64'h0123456789ABCDEF, "kat_dec", 1'b1);
        run_op(5'h1F, 64'h95F8A5E5DD31D900, ks_w, 1'b0, 64'h8000000000000000, "kat_weak", 1'b0);

        // random blocks and round trips
        for (int i = 0; i < 3; i++) begin
            ks_r = key_sched({$urandom, $urandom});
            m    = {$urandom, $urandom};
            c    = des_model(m, ks_r, 1'b0);
            run_op(5'h1F, m, ks_r, 1'b0, c, $sformatf("rand_enc%0d", i), 1'b1);
            run_op(5'h1F, c, ks_r, 1'b1, m, $sformatf("rand_dec%0d", i), 1'b1);
        end

        // start while busy is dropped
        ma   = {$urandom, $urandom};
        mb   = ~ma;
        mc   = {$urandom, $urandom};
        ks_b = key_sched({$urandom, $urandom});
        trace_u4(ma, ks_a, 1, mb, ks_b, 12);
        chk("busy_drop done_count", 64'(dk.size()), 64'd1);
        if (dk.size() > 0) begin
            chk("busy_drop latency", 64'(dk[0]), 64'd4);
            chk("busy_drop result", dr[0], des_model(ma, ks_a, 1'b0));
        end

        // start on the done cycle is accepted
        trace_u4(ma, ks_a, 4, mc, ks_b, 14);
        chk("b2b done_count", 64'(dk.size()), 64'd2);
        if (dk.size() > 1) begin
            chk("b2b first_latency", 64'(dk[0]), 64'd4);
            chk("b2b first_result", dr[0], des_model(ma, ks_a, 1'b0));
            chk("b2b second_cycle", 64'(dk[1]), 64'd9);
            chk("b2b second_result", dr[1], des_model(mc, ks_b, 1'b0));
        end

        // reset mid-run aborts silently
        @(negedge clk);
        message = {$urandom, $urandom}; round_keys = ks_a; dec = 1'b0; start_v = 5'b00100;
        @(negedge clk);
        start_v = '0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst busy", 64'(busy_v[2]), 64'd0);
        chk("midrst done", 64'(done_v[2]), 64'd0);
        chk("midrst result", result_v[2], 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        late_done = 0;
        repeat (10) begin
            @(negedge clk);
            if (done_v[2]) late_done++;
        end
        chk("midrst no_done", 64'(late_done), 64'd0);

        m = {$urandom, $urandom};
        run_op(5'h1F, m, ks_b, 1'b0, des_model(m, ks_b, 1'b0), "post_rst", 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
